// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: register-timing widths, sentinel values and mult/div latencies.
package pipeline_pkg;
    localparam int T_W = 2;
    localparam logic [T_W-1:0] TUSE_NONE = 2'd3;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;
    localparam int CNT_W_DEF = 4;
endpackage

// File: rtl/md_busy_counter.sv
// Mult/div busy down-counter: loads the op latency on start, counts to zero and holds there.
module md_busy_counter #(
    parameter int CNT_W       = 4,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (start)
            cnt <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    // The start cycle itself is busy, before the latency is loaded.
    assign busy = start | (cnt != '0);
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller: Tuse/Tnew register hazards plus mult/div busy interlock.
// Optional stall statistics counters are enabled by defining HAZARD_STALL_STATS_EN.
module hazard_stall_ctrl
    import pipeline_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [4:0]     ID_rs,
    input  logic [4:0]     ID_rt,
    input  logic [T_W-1:0] ID_Tuse_rs,
    input  logic [T_W-1:0] ID_Tuse_rt,
    input  logic           ID_md_use,
    input  logic [4:0]     E_A3,
    input  logic [T_W-1:0] E_Tnew,
    input  logic [4:0]     M_A3,
    input  logic [T_W-1:0] M_Tnew,
    input  logic           E_md_start,
    input  logic           E_md_is_div,
    output logic           stall,
    output logic           PC_WE,
    output logic           IF_ID_WE,
    output logic           ID_EX_clr,
`ifdef HAZARD_STALL_STATS_EN
    output logic [31:0]    stall_cycles,
    output logic [31:0]    md_stall_cycles,
    output logic [31:0]    md_ops,
`endif
    output logic           md_busy
);
    logic stall_rs, stall_rt, stall_md;

    md_busy_counter #(
        .CNT_W      (CNT_W),
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_busy (
        .clk   (clk),
        .reset (reset),
        .start (E_md_start),
        .is_div(E_md_is_div),
        .busy  (md_busy)
    );

    // Stall only when the operand is needed before any producer can forward it.
    assign stall_rs = (ID_rs != REG_ZERO) && (ID_Tuse_rs != TUSE_NONE) &&
                      (((E_A3 == ID_rs) && (ID_Tuse_rs < E_Tnew)) ||
                       ((M_A3 == ID_rs) && (ID_Tuse_rs < M_Tnew)));
    assign stall_rt = (ID_rt != REG_ZERO) && (ID_Tuse_rt != TUSE_NONE) &&
                      (((E_A3 == ID_rt) && (ID_Tuse_rt < E_Tnew)) ||
                       ((M_A3 == ID_rt) && (ID_Tuse_rt < M_Tnew)));
    assign stall_md = ID_md_use & md_busy;

    assign stall     = stall_rs | stall_rt | stall_md;
    assign PC_WE     = ~stall;
    assign IF_ID_WE  = ~stall;
    assign ID_EX_clr = stall;

`ifdef HAZARD_STALL_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles    <= '0;
            md_stall_cycles <= '0;
            md_ops          <= '0;
        end else begin
            if (stall)      stall_cycles    <= stall_cycles + 32'd1;
            if (stall_md)   md_stall_cycles <= md_stall_cycles + 32'd1;
            if (E_md_start) md_ops          <= md_ops + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios then randomized cycles vs. a reference model.
module tb_hazard_stall_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] ID_rs, ID_rt, E_A3, M_A3;
    logic [1:0] ID_Tuse_rs, ID_Tuse_rt, E_Tnew, M_Tnew;
    logic       ID_md_use, E_md_start, E_md_is_div;
    logic       stall, PC_WE, IF_ID_WE, ID_EX_clr, md_busy;
`ifdef HAZARD_STALL_STATS_EN
    logic [31:0] stall_cycles, md_stall_cycles, md_ops;
    int unsigned m_stall_cycles, m_md_stall_cycles, m_md_ops;
`endif

    always #5 clk = ~clk;

    hazard_stall_ctrl dut (
        .clk(clk), .reset(reset),
        .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_Tuse_rs(ID_Tuse_rs), .ID_Tuse_rt(ID_Tuse_rt),
        .ID_md_use(ID_md_use),
        .E_A3(E_A3), .E_Tnew(E_Tnew),
        .M_A3(M_A3), .M_Tnew(M_Tnew),
        .E_md_start(E_md_start), .E_md_is_div(E_md_is_div),
        .stall(stall), .PC_WE(PC_WE), .IF_ID_WE(IF_ID_WE), .ID_EX_clr(ID_EX_clr),
`ifdef HAZARD_STALL_STATS_EN
        .stall_cycles(stall_cycles), .md_stall_cycles(md_stall_cycles), .md_ops(md_ops),
`endif
        .md_busy(md_busy)
    );

    int n_vec = 0;
    int n_bad = 0;
    longint cyc = 0;
    longint busy_until = -1;  // last cycle index on which the mult/div unit is still busy

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit hz(input int src, input int tuse, input int ea3, input int etnew,
                              input int ma3, input int mtnew);
        if (src == 0 || tuse == 3) return 1'b0;
        return (ea3 == src && tuse < etnew) || (ma3 == src && tuse < mtnew);
    endfunction

    task automatic clear_in();
        ID_rs = 0; ID_rt = 0; ID_Tuse_rs = 0; ID_Tuse_rt = 0; ID_md_use = 0;
        E_A3 = 0; E_Tnew = 0; M_A3 = 0; M_Tnew = 0; E_md_start = 0; E_md_is_div = 0;
    endtask

    // Checks the current cycle at the falling edge, advances the model, and returns 1 ns after the next rising edge.
    task automatic cycle_check(input int exp_stall);
        bit e_busy, e_smd, e_stall;
        @(negedge clk);
        e_busy  = E_md_start || (cyc <= busy_until);
        e_smd   = ID_md_use && e_busy;
        e_stall = hz(ID_rs, ID_Tuse_rs, E_A3, E_Tnew, M_A3, M_Tnew) ||
                  hz(ID_rt, ID_Tuse_rt, E_A3, E_Tnew, M_A3, M_Tnew) || e_smd;
        if (exp_stall >= 0) chk("stall_directed", {31'd0, stall}, exp_stall[31:0]);
        chk("stall",     {31'd0, stall},     {31'd0, e_stall});
        chk("PC_WE",     {31'd0, PC_WE},     {31'd0, !e_stall});
        chk("IF_ID_WE",  {31'd0, IF_ID_WE},  {31'd0, !e_stall});
        chk("ID_EX_clr", {31'd0, ID_EX_clr}, {31'd0, e_stall});
        chk("md_busy",   {31'd0, md_busy},   {31'd0, e_busy});
`ifdef HAZARD_STALL_STATS_EN
        chk("stall_cycles",    stall_cycles,    m_stall_cycles);
        chk("md_stall_cycles", md_stall_cycles, m_md_stall_cycles);
        chk("md_ops",          md_ops,          m_md_ops);
        if (reset) begin
            m_stall_cycles = 0; m_md_stall_cycles = 0; m_md_ops = 0;
        end else begin
            m_stall_cycles    += e_stall;
            m_md_stall_cycles += e_smd;
            m_md_ops          += E_md_start;
        end
`endif
        if (reset)           busy_until = cyc;
        else if (E_md_start) busy_until = cyc + (E_md_is_div ? 10 : 5);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_in();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
`ifdef HAZARD_STALL_STATS_EN
        m_stall_cycles = 0; m_md_stall_cycles = 0; m_md_ops = 0;
`endif
        // Reset state with nop inputs
        cycle_check(0);
        reset = 1'b0;
        cycle_check(0);

        // Load-use, then forwarding from MEM covers it
        E_A3 = 8; E_Tnew = 2; ID_rs = 8; ID_Tuse_rs = 1;
        cycle_check(1);
        E_A3 = 0; E_Tnew = 0; M_A3 = 8; M_Tnew = 1;
        cycle_check(0);

        // $0 and unused operand never stall
        clear_in();
        E_A3 = 0; ID_rs = 0; ID_Tuse_rs = 0; E_Tnew = 2;
        cycle_check(0);
        ID_rt = 9; ID_Tuse_rt = 3; E_A3 = 9;
        cycle_check(0);

        // Mult: busy for the start cycle plus five counted cycles
        clear_in();
        ID_md_use = 1; E_md_start = 1; E_md_is_div = 0;
        cycle_check(1);
        E_md_start = 0;
        repeat (5) cycle_check(1);
        cycle_check(0);

        // Div aborted by reset when six cycles remain
        E_md_start = 1; E_md_is_div = 1;
        cycle_check(1);
        E_md_start = 0; E_md_is_div = 0;
        repeat (4) cycle_check(1);
        reset = 1'b1;
        cycle_check(1);
        reset = 1'b0;
        cycle_check(0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            ID_rs       = 5'($urandom_range(0, 3));
            ID_rt       = 5'($urandom_range(0, 3));
            ID_Tuse_rs  = 2'($urandom_range(0, 3));
            ID_Tuse_rt  = 2'($urandom_range(0, 3));
            ID_md_use   = ($urandom_range(0, 2) == 0);
            E_A3        = 5'($urandom_range(0, 3));
            E_Tnew      = 2'($urandom_range(0, 2));
            M_A3        = 5'($urandom_range(0, 3));
            M_Tnew      = 2'($urandom_range(0, 1));
            E_md_start  = ($urandom_range(0, 7) == 0);
            E_md_is_div = 1'($urandom_range(0, 1));
            reset       = ($urandom_range(0, 49) == 0);
            cycle_check(-1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
